// File: rtl/mem_req_ctrl.sv
// Data-memory initiator: latches one load/store, issues it with stall retry, waits the read latency.
// Optional MEMREQ_TIMEOUT_EN aborts an issue that stays stalled for TIMEOUT consecutive cycles.
module mem_req_ctrl #(
    parameter int LATENCY = 2,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        halt,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 7 || TIMEOUT < 1 || TIMEOUT > 31) begin : g_param_check
        $error("mem_req_ctrl: LATENCY must be 1..7 and TIMEOUT 1..31");
    end

    state_t      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
`ifdef MEMREQ_TIMEOUT_EN
    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);
    logic [4:0]  stall_cnt_q, stall_cnt_d;
`endif

    logic req;
    logic bad;

    assign req = (cpu_rd | cpu_wr) & ~halt;
    assign bad = cpu_addr[0] | (cpu_rd & cpu_wr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_wr_q     <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            rdata_q     <= 16'h0000;
            err_q       <= 1'b0;
            lat_cnt_q   <= 3'd0;
`ifdef MEMREQ_TIMEOUT_EN
            stall_cnt_q <= 5'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            lat_cnt_q   <= lat_cnt_d;
`ifdef MEMREQ_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        lat_cnt_d   = lat_cnt_q;
`ifdef MEMREQ_TIMEOUT_EN
        stall_cnt_d = stall_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    // Malformed requests finish with an error and never touch memory.
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        op_wr_d = cpu_wr;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_stall) begin
`ifdef MEMREQ_TIMEOUT_EN
                    if (stall_cnt_q == TMO_LAST) begin
                        stall_cnt_d = 5'd0;
                        err_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 5'd1;
                    end
`endif
                end else begin
`ifdef MEMREQ_TIMEOUT_EN
                    stall_cnt_d = 5'd0;
`endif
                    if (op_wr_q) begin
                        state_d = S_DONE;
                    end else begin
                        lat_cnt_d = LAT_INIT;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (state_q == S_ISSUE) & ~op_wr_q;
        mem_wr    = (state_q == S_ISSUE) & op_wr_q;
        cpu_done  = (state_q == S_DONE);
        err       = (state_q == S_DONE) & err_q;
        cpu_stall = (state_q == S_ISSUE) | (state_q == S_WAIT) | ((state_q == S_IDLE) & req);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_rdata = rdata_q;
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: random loads/stores against a word-array reference model,
// with a stalling memory responder. Expectations follow MEMREQ_TIMEOUT_EN when it is defined.
module tb_mem_req_ctrl;

    localparam int LAT = 2;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [15:0] cpu_wdata = 16'h0;
    logic        halt = 1'b0;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_stall = 1'b0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.LATENCY(LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .halt(halt), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cpu_done(cpu_done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_stall(mem_stall)
    );

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } resp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    resp_t       exp_q[$];
    resp_t       mon_exp;
    logic [15:0] mem_arr [64];
    logic [15:0] ref_mem [64];
    logic [15:0] ref_rdata = 16'h0;

    bit          exp_active = 0;
    bit          exp_wr = 0;
    logic [15:0] exp_addr = 16'h0;
    logic [15:0] exp_wdata = 16'h0;
    int          stall_cycles = 0;
    bit          force_stall = 0;
    bit          force_nostall = 0;
    int          stall_run = 0;
    bit          due_valid = 0;
    int          due_cyc = 0;
    logic [5:0]  due_idx = 6'd0;
    logic        stall_now;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: random bounded stalls, accepts strobes, returns read data LAT cycles later.
    always @(negedge clk) begin : responder
        stall_now = force_stall || (!force_nostall && stall_run < 4 && $urandom_range(0, 2) == 0);
        stall_run = stall_now ? stall_run + 1 : 0;
        mem_stall = stall_now;
        if (due_valid && cyc == due_cyc) begin
            mem_rdata = mem_arr[due_idx];
            due_valid = 0;
        end else begin
            mem_rdata = 16'($urandom);
        end
        if (!rst && (mem_rd || mem_wr)) begin
            if (!exp_active) begin
                check_output("strobe_unexpected", {30'd0, mem_rd, mem_wr}, 32'd0);
            end else begin
                check_output("strobe_op", {30'd0, mem_rd, mem_wr}, exp_wr ? 32'd1 : 32'd2);
                check_output("mem_addr", mem_addr, exp_addr);
                if (exp_wr) check_output("mem_wdata", mem_wdata, exp_wdata);
                if (stall_now) begin
                    stall_cycles++;
                end else begin
                    exp_active = 0;
                    if (mem_wr) begin
                        mem_arr[mem_addr[6:1]] = mem_wdata;
                    end else begin
                        due_valid = 1;
                        due_cyc   = cyc + LAT;
                        due_idx   = mem_addr[6:1];
                    end
                end
            end
        end
    end

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_done) begin
                if (exp_q.size() == 0) begin
                    check_output("done_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_output("resp_err", {31'd0, err}, {31'd0, mon_exp.err});
                    check_output("resp_rdata", cpu_rdata, mon_exp.rdata);
                end
            end else if (err) begin
                check_output("err_without_done", 32'd1, 32'd0);
            end
        end
    end

    task automatic apply_stimulus(input bit rd, input bit wr, input logic [15:0] addr,
                                  input logic [15:0] wdata, input int halt_at, input bit stuck);
        bit    bad;
        bit    got;
        bit    timed_out;
        int    start;
        int    exp_lat;
        resp_t e;
        @(negedge clk);
        bad       = addr[0] | (rd & wr);
        timed_out = 0;
`ifdef MEMREQ_TIMEOUT_EN
        timed_out = stuck;
`endif
        if (bad || timed_out) begin
            e = '{1'b1, ref_rdata};
        end else if (wr) begin
            ref_mem[addr[6:1]] = wdata;
            e = '{1'b0, ref_rdata};
        end else begin
            ref_rdata = ref_mem[addr[6:1]];
            e = '{1'b0, ref_rdata};
        end
        exp_q.push_back(e);
        if (!bad) begin
            exp_active = 1;
            exp_wr     = wr;
            exp_addr   = addr;
            exp_wdata  = wdata;
        end
        stall_cycles = 0;
        force_stall  = stuck;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        halt      = 1'b0;
        start     = cyc;
        got       = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            #1;
            if (cpu_done) begin
                got = 1;
            end else begin
                check_output("stall_busy", {31'd0, cpu_stall}, 32'd1);
                if (n == halt_at) halt = 1'b1;
                if (stuck && n == 105) begin
                    check_output("still_issue", {31'd0, mem_rd}, 32'd1);
                    force_stall = 0;
                end
                @(negedge clk);
            end
        end
        force_stall = 0;
        if (!got) begin
            check_output("done_timeout", 32'd0, 32'd1);
        end else begin
            check_output("stall_in_done", {31'd0, cpu_stall}, 32'd0);
            if (bad) exp_lat = 1;
            else if (timed_out) exp_lat = TMO + 1;
            else exp_lat = 2 + stall_cycles + (wr ? 0 : LAT);
            check_output("latency", cyc - start, exp_lat);
        end
        exp_active = 0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        halt   = 1'b0;
    endtask

    task automatic halt_block();
        @(negedge clk);
        halt     = 1'b1;
        cpu_rd   = 1'b1;
        cpu_addr = 16'h0010;
        #1 check_output("halt_stall", {31'd0, cpu_stall}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            #1;
            check_output("halt_stall", {31'd0, cpu_stall}, 32'd0);
            check_output("halt_done", {31'd0, cpu_done}, 32'd0);
        end
        cpu_rd = 1'b0;
        halt   = 1'b0;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        force_nostall = 1;
        exp_active = 1;
        exp_wr     = 0;
        exp_addr   = 16'h0040;
        cpu_rd     = 1'b1;
        cpu_addr   = 16'h0040;
        cpu_wdata  = 16'hA5A5;
        repeat (2) @(negedge clk);
        cpu_rd = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_output("rst_done", {31'd0, cpu_done}, 32'd0);
        check_output("rst_err", {31'd0, err}, 32'd0);
        check_output("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'd0);
        check_output("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_output("rst_stall", {31'd0, cpu_stall}, 32'd0);
        due_valid     = 0;
        exp_active    = 0;
        ref_rdata     = 16'h0;
        force_nostall = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            check_output("post_rst_done", {31'd0, cpu_done}, 32'd0);
            check_output("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
        end
    endtask

    initial begin
        logic [15:0] v;
        int          r;
        logic [15:0] a;
        for (int i = 0; i < 64; i++) begin
            v = 16'($urandom);
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        mem_arr[8] = 16'hBEEF;
        ref_mem[8] = 16'hBEEF;

        repeat (2) @(negedge clk);
        #1;
        check_output("reset_rdata", cpu_rdata, 32'd0);
        check_output("reset_mem_addr", mem_addr, 32'd0);
        check_output("reset_mem_wdata", mem_wdata, 32'd0);
        check_output("reset_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        check_output("reset_done_err", {30'd0, cpu_done, err}, 32'd0);
        check_output("reset_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        force_nostall = 1;
        apply_stimulus(1'b1, 1'b0, 16'h0010, 16'h0000, -1, 1'b0);
        force_nostall = 0;
        apply_stimulus(1'b0, 1'b1, 16'h0020, 16'h1234, -1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 16'h0003, 16'h0000, -1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 16'h0004, 16'h0000, -1, 1'b0);
        halt_block();
        apply_stimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 3, 1'b0);
        reset_mid();

        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 9));
            a = {9'd0, 6'($urandom), 1'b0};
            if (r == 0) a[0] = 1'b1;
            apply_stimulus(r <= 5 || r == 1, r == 1 || r >= 6, a, 16'($urandom),
                           ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : -1, 1'b0);
        end

        apply_stimulus(1'b1, 1'b0, 16'h0010, 16'h0000, -1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 16'h0020, 16'h0000, -1, 1'b0);

        repeat (3) @(negedge clk);
        check_output("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
